// File: rtl/rf_writeback.sv
// Register-file write-back initiator: merges load returns and ALU results
// in program order onto the single write port and tracks pending writes.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   alu_valid/alu_rd/alu_data  ALU result, available this cycle
//   ld_issue/ld_rd/ld_funct3/ld_addr_lo  load issued to data RAM
//   mem_rdata                  RAM word, valid the cycle after ld_issue
//   wen/wraddr/wrdata          registered register-file write port
//   pend_mask                  rd bits with a write in flight/queued/in output
//   stall                      upstream must hold off ALU results and loads
//   ovf                        sticky: a queue entry was dropped
module rf_writeback #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_issue,
   input  logic [4:0]      ld_rd,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wen,
   output logic [4:0]      wraddr,
   output logic [XLEN-1:0] wrdata,
   output logic [31:0]     pend_mask,
   output logic            stall,
   output logic            ovf
);

   localparam int NC = DEPTH + 2;
   localparam int CW = $clog2(DEPTH + 1);

   logic            ld_v;
   logic [4:0]      ld_rd_q;
   logic [2:0]      ld_f3_q;
   logic [1:0]      ld_lo_q;
   logic [CW-1:0]   cnt;
   logic [4:0]      q_rd  [DEPTH];
   logic [XLEN-1:0] q_dat [DEPTH];

   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic [XLEN-1:0] ld_res;
   logic            ld_ok;
   logic            alu_ok;

   // Candidate list in program order: queue, then load return, then ALU.
   logic [4:0]      c_rd  [NC];
   logic [XLEN-1:0] c_dat [NC];
   int              n_ld;
   int              n_alu;
   int              n_tot;

   always_comb begin
      ld_b = mem_rdata[{ld_lo_q, 3'b000} +: 8];
      ld_h = ld_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_f3_q)
         3'b000:  ld_res = {{(XLEN-8){ld_b[7]}}, ld_b};
         3'b100:  ld_res = {{(XLEN-8){1'b0}}, ld_b};
         3'b001:  ld_res = {{(XLEN-16){ld_h[15]}}, ld_h};
         3'b101:  ld_res = {{(XLEN-16){1'b0}}, ld_h};
         default: ld_res = mem_rdata;
      endcase
   end

   // x0 writes are dropped before they can take a slot.
   assign ld_ok  = ld_v && (ld_rd_q != 5'd0);
   assign alu_ok = alu_valid && (alu_rd != 5'd0);

   always_comb begin
      n_ld  = int'(cnt);
      n_alu = n_ld + (ld_ok ? 1 : 0);
      n_tot = n_alu + (alu_ok ? 1 : 0);
      for (int i = 0; i < NC; i++) begin
         c_rd[i]  = '0;
         c_dat[i] = '0;
         if (ld_ok && i == n_ld) begin
            c_rd[i]  = ld_rd_q;
            c_dat[i] = ld_res;
         end
         if (alu_ok && i == n_alu) begin
            c_rd[i]  = alu_rd;
            c_dat[i] = alu_data;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (i < n_ld) begin
            c_rd[i]  = q_rd[i];
            c_dat[i] = q_dat[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_v    <= 1'b0;
         ld_rd_q <= '0;
         ld_f3_q <= '0;
         ld_lo_q <= '0;
         cnt     <= '0;
         wen     <= 1'b0;
         wraddr  <= '0;
         wrdata  <= '0;
         ovf     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            q_rd[i]  <= '0;
            q_dat[i] <= '0;
         end
      end else begin
         ld_v    <= ld_issue;
         ld_rd_q <= ld_rd;
         ld_f3_q <= ld_funct3;
         ld_lo_q <= ld_addr_lo;
         if (n_tot > 0) begin
            wen    <= 1'b1;
            wraddr <= c_rd[0];
            wrdata <= c_dat[0];
         end else begin
            wen <= 1'b0;
         end
         // Remaining candidates shift into the queue; beyond DEPTH the
         // youngest are lost.
         for (int i = 0; i < DEPTH; i++) begin
            q_rd[i]  <= c_rd[i+1];
            q_dat[i] <= c_dat[i+1];
         end
         if (n_tot == 0)
            cnt <= '0;
         else if (n_tot - 1 > DEPTH)
            cnt <= CW'(DEPTH);
         else
            cnt <= CW'(n_tot - 1);
         if (n_tot - 1 > DEPTH)
            ovf <= 1'b1;
      end
   end

   always_comb begin
      pend_mask = '0;
      if (ld_v)
         pend_mask[ld_rd_q] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(cnt))
            pend_mask[q_rd[i]] = 1'b1;
      end
      if (wen)
         pend_mask[wraddr] = 1'b1;
      pend_mask[0] = 1'b0;
   end

   assign stall = (int'(cnt) + (ld_v ? 1 : 0)) >= DEPTH - 1;

endmodule

// File: tb/tb_rf_writeback.sv
// Randomized and directed bench for rf_writeback against a queue-based
// model of program-order write-back.
module tb_rf_writeback;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic [31:0] mem_rdata;
   logic        wen;
   logic [4:0]  wraddr;
   logic [31:0] wrdata;
   logic [31:0] pend_mask;
   logic        stall;
   logic        ovf;

   rf_writeback #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
      .ld_addr_lo(ld_addr_lo), .mem_rdata(mem_rdata),
      .wen(wen), .wraddr(wraddr), .wrdata(wrdata),
      .pend_mask(pend_mask), .stall(stall), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } wr_t;

   wr_t         mq[$];
   logic        m_wen, m_ldv, m_ovf;
   logic [4:0]  m_rd, m_ldrd;
   logic [31:0] m_dat;
   logic [2:0]  m_ldf3;
   logic [1:0]  m_ldlo;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [2:0] f,
                                       input logic [1:0] lo,
                                       input logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * lo)) & 255;
      h = (w >> (16 * lo[1])) & 65535;
      case (f)
         3'd0:    return (b >= 128) ? b - 256 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h - 65536 : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic model_stall();
      return (mq.size() + (m_ldv ? 1 : 0)) >= DEPTH - 1;
   endfunction

   function automatic logic [31:0] exp_pend();
      logic [31:0] p = '0;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      if (m_ldv) p[m_ldrd] = 1'b1;
      if (m_wen) p[m_rd] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_wen = 0; m_ldv = 0; m_ovf = 0;
      m_rd = 0; m_ldrd = 0; m_dat = 0; m_ldf3 = 0; m_ldlo = 0;
   endtask

   task automatic model_step();
      wr_t lst[$];
      wr_t h;
      lst = mq;
      if (m_ldv && m_ldrd != 0)
         lst.push_back('{m_ldrd, ext(m_ldf3, m_ldlo, mem_rdata)});
      if (alu_valid && alu_rd != 0)
         lst.push_back('{alu_rd, alu_data});
      if (lst.size() > 0) begin
         h = lst.pop_front();
         m_wen = 1; m_rd = h.rd; m_dat = h.d;
      end else begin
         m_wen = 0;
      end
      while (lst.size() > DEPTH) begin
         void'(lst.pop_back());
         m_ovf = 1;
      end
      mq = lst;
      m_ldv = ld_issue; m_ldrd = ld_rd;
      m_ldf3 = ld_funct3; m_ldlo = ld_addr_lo;
   endtask

   task automatic check_outs();
      check("wen", wen, m_wen);
      check("wraddr", wraddr, m_rd);
      check("wrdata", wrdata, m_dat);
      check("pend_mask", pend_mask, exp_pend());
      check("stall", stall, model_stall());
      check("ovf", ovf, m_ovf);
   endtask

   task automatic cycle(input logic av, input logic [4:0] ar,
                        input logic [31:0] ad, input logic li,
                        input logic [4:0] lr, input logic [2:0] lf,
                        input logic [1:0] ll, input logic [31:0] md);
      alu_valid = av; alu_rd = ar; alu_data = ad;
      ld_issue = li; ld_rd = lr; ld_funct3 = lf; ld_addr_lo = ll;
      mem_rdata = md;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outs();
   endtask

   task automatic idle(input logic [31:0] md);
      cycle(0, 0, 0, 0, 0, 0, 0, md);
   endtask

   task automatic clr_inputs();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_issue = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
      mem_rdata = 0;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 0;
      clr_inputs();
      #1;
      check({tag, "_wen"}, wen, 0);
      check({tag, "_wraddr"}, wraddr, 0);
      check({tag, "_wrdata"}, wrdata, 0);
      check({tag, "_pend"}, pend_mask, 0);
      check({tag, "_stall"}, stall, 0);
      check({tag, "_ovf"}, ovf, 0);
      model_reset();
      #2 rst_n = 1;
      @(negedge clk);
   endtask

   logic [2:0]  t2_f3 [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
   logic [1:0]  t2_lo [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
   logic [31:0] t2_ex [4] = '{32'hFFFFFFF2, 32'h00000080,
                              32'hFFFF8081, 32'h8081F2F3};

   initial begin
      logic st;
      int   k;
      rst_n = 0;
      clr_inputs();
      model_reset();
      #3;
      check("rst_wen", wen, 0);
      check("rst_pend", pend_mask, 0);
      check("rst_stall", stall, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1;
      @(negedge clk);

      // ALU write, one-cycle latency, pend bit only while in output reg
      cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0);
      check("t1_wen", wen, 1);
      check("t1_addr", wraddr, 5);
      check("t1_data", wrdata, 32'h1234);
      check("t1_pend5", pend_mask[5], 1);
      idle(0);
      check("t1_pend5_off", pend_mask[5], 0);

      // load extensions, written at issue+2
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 1, 9, t2_f3[i], t2_lo[i], $urandom);
         check("t2_wen_n1", wen, 0);
         check("t2_pend9", pend_mask[9], 1);
         idle(32'h8081F2F3);
         check("t2_wen_n2", wen, 1);
         check("t2_addr", wraddr, 9);
         check("t2_data", wrdata, t2_ex[i]);
         idle(0);
      end

      // WAW on x7: load older than following ALU
      cycle(0, 0, 0, 1, 7, 3'd2, 0, 0);
      cycle(1, 7, 32'h1, 0, 0, 0, 0, 32'hCAFE0001);
      check("t3_first", wrdata, 32'hCAFE0001);
      idle(0);
      check("t3_second_wen", wen, 1);
      check("t3_second", wrdata, 32'h1);
      idle(0);

      // x0 writes vanish
      cycle(1, 0, 32'hDEAD, 1, 0, 3'd2, 0, 0);
      cycle(1, 0, 32'hBEEF, 0, 0, 0, 0, 32'h5555);
      check("t4_wen", wen, 0);
      check("t4_pend", pend_mask, 0);
      idle(0);
      check("t4_wen2", wen, 0);

      // load+ALU pairs obeying stall; reset with 2 queued + 1 in flight
      k = 0;
      while (!(mq.size() == 2 && m_ldv) && k < 20) begin
         st = model_stall();
         if (st) idle($urandom);
         else cycle(1, 5'($urandom_range(1, 31)), $urandom, 1,
                    5'($urandom_range(1, 31)), 3'($urandom),
                    2'($urandom), $urandom);
         k++;
      end
      check("t5_reached", k < 20, 1);
      check("t5_ovf", ovf, 0);
      do_reset("t6");
      for (int i = 0; i < 4; i++) idle($urandom);
      check("t6_no_stale", wen, 0);

      // ignore stall to force overflow
      for (int i = 0; i < 6; i++)
         cycle(1, 5'(i + 1), $urandom, 1, 5'(i + 10), 3'd2, 0, $urandom);
      check("ovf_set", ovf, 1);
      for (int i = 0; i < 6; i++) idle($urandom);
      check("ovf_sticky", ovf, 1);
      do_reset("ovf_rst");

      // random traffic obeying stall
      for (int n = 0; n < 600; n++) begin
         st = model_stall();
         if (n % 150 == 149) begin
            do_reset("rand_rst");
         end else if (st) begin
            idle($urandom);
         end else begin
            cycle(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 3'($urandom), 2'($urandom),
                  $urandom);
         end
      end
      check("rand_ovf", ovf, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
